// File: rtl/sum_window_accumulator_if.sv
// Handshake bundle between the adder-stage sample source, the window accumulator
// and the downstream result consumer.
interface sum_window_accumulator_if #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       sum_in;
  logic             cout_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] count_out;
  logic             sat_out;

  modport master (
    output in_valid, sum_in, cout_in, flush, out_ready,
    input  in_ready, out_valid, acc_out, count_out, sat_out
  );

  modport slave (
    input  in_valid, sum_in, cout_in, flush, out_ready,
    output in_ready, out_valid, acc_out, count_out, sat_out
  );
endinterface

// File: rtl/sum_window_accumulator.sv
// Sums windows of 4-bit adder results {cout,sum} with saturation and presents each
// window total, sample count and sticky saturation flag on a valid/ready port.
module sum_window_accumulator #(
  parameter int ACC_W  = 8,
  parameter int WINDOW = 4,
  parameter int CNT_W  = 3
) (
  input logic                     clk,
  input logic                     rst,
  sum_window_accumulator_if.slave bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic [ACC_W-1:0] r_acc_out;
  logic [CNT_W-1:0] r_count_out;
  logic             r_sat_out;

  state_t           w_state_next;
  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_sat_next;
  logic             w_load_out;

  logic [ACC_W:0]   w_sum;
  logic             w_ovf;
  logic [ACC_W-1:0] w_acc_sat;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_full;
  logic             w_flush_close;

  // One extra bit on the adder exposes overflow for the clamp.
  assign w_sum       = {1'b0, r_acc} + {{(ACC_W-3){1'b0}}, bus.cout_in, bus.sum_in};
  assign w_ovf       = w_sum[ACC_W];
  assign w_acc_sat   = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  assign w_count_inc = r_count + 1'b1;
  assign w_full      = bus.in_valid && (w_count_inc == CNT_W'(WINDOW));
  assign w_flush_close = bus.flush && (bus.in_valid || (r_count != '0));

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_count_next = r_count;
    w_sat_next   = r_sat;
    w_load_out   = 1'b0;
    case (r_state)
      ACCUM: begin
        if (bus.in_valid) begin
          w_acc_next   = w_acc_sat;
          w_count_next = w_count_inc;
          w_sat_next   = r_sat | w_ovf;
        end
        if (w_full || w_flush_close) begin
          w_state_next = HOLD;
          w_load_out   = 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_state_next = ACCUM;
          w_acc_next   = '0;
          w_count_next = '0;
          w_sat_next   = 1'b0;
        end
      end
      default: w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_count     <= '0;
      r_sat       <= 1'b0;
      r_acc_out   <= '0;
      r_count_out <= '0;
      r_sat_out   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_count <= w_count_next;
      r_sat   <= w_sat_next;
      if (w_load_out) begin
        r_acc_out   <= w_acc_next;
        r_count_out <= w_count_next;
        r_sat_out   <= w_sat_next;
      end
    end
  end

  // Handshake outputs depend on state only, so no input-to-output comb path.
  assign bus.in_ready  = (r_state == ACCUM);
  assign bus.out_valid = (r_state == HOLD);
  assign bus.acc_out   = r_acc_out;
  assign bus.count_out = r_count_out;
  assign bus.sat_out   = r_sat_out;

endmodule

// File: tb/tb_sum_window_accumulator.sv
// Scoreboard bench: directed windows push expected results, per-DUT monitors compare
// every presented result (including stability while stalled) and pop on handshake.
module tb_sum_window_accumulator;

  typedef struct {
    logic [7:0] acc;
    logic [2:0] cnt;
    logic       sat;
  } result_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  result_t qa[$];
  result_t qb[$];

  always #5 clk = ~clk;

  sum_window_accumulator_if #(.ACC_W(8), .CNT_W(3)) a_if ();
  sum_window_accumulator_if #(.ACC_W(4), .CNT_W(3)) b_if ();

  sum_window_accumulator #(.ACC_W(8), .WINDOW(4), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave)
  );
  sum_window_accumulator #(.ACC_W(4), .WINDOW(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end else begin
      $display("ok   %s value=%0d", name, actual);
    end
  endtask

  // Monitors: compare whatever is presented against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && a_if.out_valid) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_result actual=%0d expected=none", a_if.acc_out);
      end else begin
        checks++;
        if (a_if.acc_out !== qa[0].acc || a_if.count_out !== qa[0].cnt || a_if.sat_out !== qa[0].sat) begin
          errors++;
          $display("FAIL a_result actual=%0d/%0d/%0d expected=%0d/%0d/%0d", a_if.acc_out,
                   a_if.count_out, a_if.sat_out, qa[0].acc, qa[0].cnt, qa[0].sat);
        end else if (a_if.out_ready) begin
          $display("ok   a_result acc=%0d cnt=%0d sat=%0d", a_if.acc_out, a_if.count_out, a_if.sat_out);
        end
        if (a_if.out_ready) void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_if.out_valid) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_result actual=%0d expected=none", b_if.acc_out);
      end else begin
        checks++;
        if ({4'b0, b_if.acc_out} !== qb[0].acc || b_if.count_out !== qb[0].cnt || b_if.sat_out !== qb[0].sat) begin
          errors++;
          $display("FAIL b_result actual=%0d/%0d/%0d expected=%0d/%0d/%0d", b_if.acc_out,
                   b_if.count_out, b_if.sat_out, qb[0].acc, qb[0].cnt, qb[0].sat);
        end else if (b_if.out_ready) begin
          $display("ok   b_result acc=%0d cnt=%0d sat=%0d", b_if.acc_out, b_if.count_out, b_if.sat_out);
        end
        if (b_if.out_ready) void'(qb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [3:0] v, input bit f);
    if (sel) begin
      b_if.in_valid = 1'b1; {b_if.cout_in, b_if.sum_in} = v; b_if.flush = f;
    end else begin
      a_if.in_valid = 1'b1; {a_if.cout_in, a_if.sum_in} = v; a_if.flush = f;
    end
    tick();
    a_if.in_valid = 1'b0; a_if.flush = 1'b0;
    b_if.in_valid = 1'b0; b_if.flush = 1'b0;
  endtask

  task automatic flush_only(input bit sel);
    if (sel) b_if.flush = 1'b1; else a_if.flush = 1'b1;
    tick();
    a_if.flush = 1'b0; b_if.flush = 1'b0;
  endtask

  task automatic expect_hold(input bit sel, input string name);
    check({name, "_out_valid"}, sel ? b_if.out_valid : a_if.out_valid, 1);
    check({name, "_in_ready"},  sel ? b_if.in_ready  : a_if.in_ready,  0);
  endtask

  task automatic release_result(input bit sel, input string name);
    if (sel) b_if.out_ready = 1'b1; else a_if.out_ready = 1'b1;
    tick();
    a_if.out_ready = 1'b0; b_if.out_ready = 1'b0;
    check({name, "_valid_drop"}, sel ? b_if.out_valid : a_if.out_valid, 0);
    check({name, "_ready_back"}, sel ? b_if.in_ready  : a_if.in_ready,  1);
  endtask

  task automatic expect_reset_state(input string name);
    check({name, "_a_ready"}, a_if.in_ready, 1);
    check({name, "_a_valid"}, a_if.out_valid, 0);
    check({name, "_a_outs"},  {a_if.acc_out, a_if.count_out, a_if.sat_out}, 0);
    check({name, "_b_ready"}, b_if.in_ready, 1);
    check({name, "_b_outs"},  {b_if.acc_out, b_if.count_out, b_if.sat_out}, 0);
  endtask

  initial begin
    a_if.in_valid = 0; a_if.sum_in = 0; a_if.cout_in = 0; a_if.flush = 0; a_if.out_ready = 0;
    b_if.in_valid = 0; b_if.sum_in = 0; b_if.cout_in = 0; b_if.flush = 0; b_if.out_ready = 0;
    repeat (3) tick();
    rst = 1'b0;
    expect_reset_state("reset");

    // Full window 3,5,15,1 = 24, then a 5-cycle stall with noisy inputs.
    qa.push_back('{acc: 8'd24, cnt: 3'd4, sat: 1'b0});
    send(0, 4'd3, 0); send(0, 4'd5, 0); send(0, 4'd15, 0); send(0, 4'd1, 0);
    expect_hold(0, "w24");
    for (int i = 0; i < 5; i++) begin
      a_if.in_valid = i[0]; a_if.sum_in = 3'(i + 3); a_if.cout_in = i[1]; a_if.flush = i[0];
      tick();
      check("stall_in_ready", a_if.in_ready, 0);
    end
    a_if.in_valid = 0; a_if.flush = 0;
    release_result(0, "w24");

    // Partial window 7,9 closed by a bare flush.
    qa.push_back('{acc: 8'd16, cnt: 3'd2, sat: 1'b0});
    send(0, 4'd7, 0); send(0, 4'd9, 0);
    flush_only(0);
    expect_hold(0, "w16");
    release_result(0, "w16");

    // Flush on an empty window must be ignored.
    flush_only(0);
    for (int i = 0; i < 3; i++) begin
      check("empty_flush_no_valid", a_if.out_valid, 0);
      tick();
    end

    // Flush together with the 3rd sample, then with the 4th sample.
    qa.push_back('{acc: 8'd10, cnt: 3'd3, sat: 1'b0});
    send(0, 4'd2, 0); send(0, 4'd2, 0); send(0, 4'd6, 1);
    expect_hold(0, "w10");
    release_result(0, "w10");
    qa.push_back('{acc: 8'd7, cnt: 3'd4, sat: 1'b0});
    send(0, 4'd1, 0); send(0, 4'd1, 0); send(0, 4'd1, 0); send(0, 4'd4, 1);
    expect_hold(0, "w7");
    release_result(0, "w7");
    for (int i = 0; i < 3; i++) begin
      check("no_extra_window", a_if.out_valid, 0);
      tick();
    end

    // Saturating instance: 15,15,1,0 clamps to 15, then a clean window.
    qb.push_back('{acc: 8'd15, cnt: 3'd4, sat: 1'b1});
    send(1, 4'd15, 0); send(1, 4'd15, 0); send(1, 4'd1, 0); send(1, 4'd0, 0);
    expect_hold(1, "sat");
    release_result(1, "sat");
    qb.push_back('{acc: 8'd10, cnt: 3'd4, sat: 1'b0});
    send(1, 4'd1, 0); send(1, 4'd2, 0); send(1, 4'd3, 0); send(1, 4'd4, 0);
    expect_hold(1, "b10");
    release_result(1, "b10");

    // Reset mid-window discards the partial sum.
    send(0, 4'd5, 0); send(0, 4'd5, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    expect_reset_state("rst_mid");
    qa.push_back('{acc: 8'd10, cnt: 3'd4, sat: 1'b0});
    send(0, 4'd1, 0); send(0, 4'd2, 0); send(0, 4'd3, 0); send(0, 4'd4, 0);
    expect_hold(0, "after_rst");
    release_result(0, "after_rst");

    // Reset during HOLD drops the pending result.
    qa.push_back('{acc: 8'd8, cnt: 3'd4, sat: 1'b0});
    send(0, 4'd2, 0); send(0, 4'd2, 0); send(0, 4'd2, 0); send(0, 4'd2, 0);
    expect_hold(0, "pre_rst_hold");
    rst = 1'b1; tick(); rst = 1'b0;
    void'(qa.pop_front());
    expect_reset_state("rst_hold");
    qa.push_back('{acc: 8'd32, cnt: 3'd4, sat: 1'b0});
    send(0, 4'd8, 0); send(0, 4'd8, 0); send(0, 4'd8, 0); send(0, 4'd8, 0);
    expect_hold(0, "w32");
    release_result(0, "w32");

    tick(); tick();
    check("scoreboard_a_drained", qa.size(), 0);
    check("scoreboard_b_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_window_accumulator.md
Name: sum_window_accumulator

Overview:
- Downstream consumer of the 3-bit parallel adder stage.
- Takes each registered adder result {Cout, Sum[2:0]} as a 4-bit unsigned value (0..15) under a valid/ready handshake.
- Sums a window of WINDOW samples into a wider accumulator, then presents the window total with a sample count and a sticky saturation flag on a valid/ready output port.
- A flush input closes a partial window early.

Parameters:
- ACC_W, 8, accumulator/output width in bits; must be >= 4.
- WINDOW, 4, samples per full window; must be >= 1.
- CNT_W, 3, width of sample counter/count output; must hold WINDOW (2^CNT_W-1 >= WINDOW).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream sample present.
- in_ready  output  1  block can accept a sample this cycle.
- sum_in  input  3  adder Sum bits.
- cout_in  input  1  adder carry-out; sample value = {cout_in, sum_in}.
- flush  input  1  request to close the current window early.
- out_valid  output  1  window result presented.
- out_ready  input  1  downstream accepts result.
- acc_out  output  ACC_W  window total (saturated).
- count_out  output  CNT_W  number of samples in the presented window.
- sat_out  output  1  1 if any addition in this window saturated.

Behaviour:
- Interface: one clock domain; clk, synchronous active-high rst.
- Reset (rst=1 at a rising edge): state=ACCUM, acc=0, count=0, sat=0, out_valid=0, in_ready=1, acc_out=0, count_out=0, sat_out=0. Reset mid-window or mid-HOLD discards everything; no result is emitted.
- Two states: ACCUM and HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept when in_valid && in_ready: acc <= min(acc + {cout_in,sum_in}, 2^ACC_W-1). Sat <= sat | (true sum > 2^ACC_W-1). Count <= count+1. The addition is done at ACC_W+1 bits to detect overflow.
  - Full window: if the accepted sample makes count == WINDOW, go to HOLD next cycle. Result regs acc_out/count_out/sat_out load the updated values, which include that sample.
  - Flush: flush=1 with count>0 or an accepted sample goes to HOLD with the partial totals. A sample accepted in the same cycle as flush is included.
  - flush=1 with count==0 and no accepted sample: ignored, stays in ACCUM.
  - Flush on the same cycle as the WINDOW-th sample: single HOLD with count WINDOW; no extra empty window.
- Latency: out_valid asserts on the cycle after the closing sample/flush is sampled.
- HOLD:
  - out_valid=1, in_ready=0.
  - acc_out/count_out/sat_out are stable until handshake.
  - in_valid and flush are ignored.
  - On out_valid && out_ready: clear internal acc/count/sat, return to ACCUM, out_valid=0 next cycle. Output registers keep their last value; they are don't-care when out_valid=0.
- No combinational path from in_valid/out_ready to in_ready/out_valid. in_ready is a function of state only.
- Counter never wraps: a window closes at count==WINDOW before any overflow of CNT_W.

Test Plan:
- Reset then WINDOW=4 samples {c,s} = 3,5,15,1, in_valid held high -> out_valid one cycle after 4th accept, acc_out=24, count_out=4, sat_out=0, in_ready=0 while HOLD.
- ACC_W=4: samples 15,15,1,0 -> acc_out=15 (saturated), sat_out=1, count_out=4; next window after handshake starts at acc=0 with sat_out=0.
- Two samples 7,9 then flush with in_valid=0 -> HOLD with acc_out=16, count_out=2; flush with count=0 and in_valid=0 -> no out_valid ever.
- out_ready held low 5 cycles in HOLD while in_valid=1 toggling, sum_in changing -> acc_out/count_out stable, no samples accepted; out_ready=1 -> out_valid drops next cycle, in_ready=1.
- Flush on the same cycle as the 3rd sample (value 6) after 2,2 -> acc_out=10, count_out=3; flush on the 4th sample -> exactly one result, count_out=4.
- rst=1 after 2 accepted samples, and again during HOLD -> all outputs 0, out_valid=0, in_ready=1 next cycle; following full window sums from 0.
